// File: rtl/vpu_pkg.sv
// vpu_pkg: shared instruction fields and type codes for the VPU issue path
package vpu_pkg;

    localparam logic [2:0] VPU_SCALAR   = 3'd0;
    localparam logic [2:0] VPU_VLOAD    = 3'd1;
    localparam logic [2:0] VPU_VSTORE   = 3'd2;
    localparam logic [2:0] VPU_VCOMPUTE = 3'd3;

    typedef struct packed {
        logic [12:0] addr_a;
        logic [12:0] addr_b;
        logic [12:0] addr_out;
        logic [12:0] addr_const;
        logic [9:0]  opcode;
        logic [2:0]  vpu_type;
        logic [2:0]  vreg_dst;
        logic [2:0]  vreg_a;
        logic [2:0]  vreg_b;
        logic [2:0]  vpu_opcode;
        logic        scalar_b;
    } vpu_instr_t;

    typedef enum logic {IDLE, WAIT_DONE} issue_state_t;

endpackage

// File: rtl/vpu_instr_fifo.sv
// vpu_instr_fifo: synchronous instruction FIFO, registered count, no bypass
module vpu_instr_fifo
    import vpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  vpu_instr_t                 din_i,
    input  logic                       pop_i,
    output vpu_instr_t                 dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    vpu_instr_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q;
    logic            push_ok, pop_ok;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_ok);
            rd_q  <= rd_q + AW'(pop_ok);
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end

    // storage needs no reset; the pointers define what is valid
    always_ff @(posedge clk)
        if (push_ok) mem_q[wr_q] <= din_i;

endmodule

// File: rtl/vpu_issue_ctrl.sv
// vpu_issue_ctrl: issues queued VPU instructions one at a time, holding fields until done (optional timeout: VPU_ISSUE_TIMEOUT_EN)
module vpu_issue_ctrl
    import vpu_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid_i,
    input  vpu_instr_t                 in_instr_i,
    output logic                       in_ready_o,
    output vpu_instr_t                 vpu_instr_o,
    output logic                       vpu_start_o,
    input  logic                       vpu_done_i,
    output logic [$clog2(DEPTH+1)-1:0] q_count_o,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           retired_o,
    output logic                       err_timeout_o,
    input  logic                       err_clr_i
);
    issue_state_t     state_q;
    vpu_instr_t       instr_q, head;
    logic             start_q;
    logic [CNT_W-1:0] retired_q;
    logic             full, empty, pop, expire;

    vpu_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid_i),
        .din_i   (in_instr_i),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (q_count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    // IDLE pops whenever something is queued; WAIT_DONE only when done frees the engine
    assign pop = !empty && (state_q == IDLE || vpu_done_i);

`ifdef VPU_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);

    logic [TW-1:0] tmr_q;
    logic          err_q;

    assign expire        = state_q == WAIT_DONE && !vpu_done_i && tmr_q == TW'(TIMEOUT_CYCLES-1);
    assign err_timeout_o = err_q;

    // counts WAIT_DONE cycles since the last issue
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tmr_q <= '0;
        else tmr_q <= pop ? '0 : (state_q == WAIT_DONE) ? tmr_q + TW'(1) : tmr_q;

    // sticky timeout flag; a new timeout beats a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err_q <= 1'b0;
        else err_q <= expire ? 1'b1 : err_clr_i ? 1'b0 : err_q;
`else
    logic unused_cfg;

    assign expire        = 1'b0;
    assign err_timeout_o = 1'b0;
    assign unused_cfg    = err_clr_i ^ (TIMEOUT_CYCLES == 0);
`endif

    // sequencer: registered fields, one-cycle start, retire on done
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            start_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            start_q   <= pop;
            instr_q   <= pop ? head : instr_q;
            retired_q <= (state_q == WAIT_DONE && vpu_done_i) ? retired_q + CNT_W'(1) : retired_q;
            state_q   <= pop ? WAIT_DONE : (vpu_done_i || expire) ? IDLE : state_q;
        end

    assign in_ready_o  = !full;
    assign vpu_instr_o = instr_q;
    assign vpu_start_o = start_q;
    assign retired_o   = retired_q;
    assign busy_o      = state_q != IDLE || q_count_o != '0;

endmodule

// File: tb/tb_vpu_issue_ctrl.sv
// tb_vpu_issue_ctrl: scoreboard bench for the VPU issue sequencer
module tb_vpu_issue_ctrl;
    import vpu_pkg::*;

    localparam int CW = $clog2(4+1);

    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, err_clr = 1'b0;
    logic       man_done = 1'b0, auto_done = 1'b0, auto_en = 1'b0;
    vpu_instr_t in_instr = '0, vpu_instr;
    logic       in_ready, vpu_start, busy, err_timeout, vpu_done;
    logic [CW-1:0] q_count;
    logic [15:0]   retired;

    int n_cmp = 0, n_bad = 0, exp_ret = 0, dcnt = 0;
    vpu_instr_t exp_q[$];

    assign vpu_done = man_done | auto_done;

    always #5 clk = ~clk;

    vpu_issue_ctrl #(.DEPTH(4), .TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_instr_i    (in_instr),
        .in_ready_o    (in_ready),
        .vpu_instr_o   (vpu_instr),
        .vpu_start_o   (vpu_start),
        .vpu_done_i    (vpu_done),
        .q_count_o     (q_count),
        .busy_o        (busy),
        .retired_o     (retired),
        .err_timeout_o (err_timeout),
        .err_clr_i     (err_clr)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic vpu_instr_t mk(input logic [2:0] t, input logic [12:0] a, input logic [9:0] op);
        vpu_instr_t r;
        r            = '0;
        r.addr_a     = a;
        r.addr_b     = a + 13'd1;
        r.addr_out   = ~a;
        r.addr_const = a ^ 13'h155;
        r.opcode     = op;
        r.vpu_type   = t;
        r.vreg_dst   = op[2:0];
        r.vreg_a     = op[5:3];
        r.vreg_b     = op[8:6];
        r.vpu_opcode = t + 3'd1;
        r.scalar_b   = op[9];
        return r;
    endfunction

    // called at a negedge; presents one push for the following edge
    task automatic push(input vpu_instr_t i, output logic acc);
        in_valid = 1'b1;
        in_instr = i;
        acc      = in_ready;
        if (acc) exp_q.push_back(i);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        int k = 0;
        while (!vpu_start && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("start_seen", vpu_start, 1);
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        @(negedge clk);
        man_done = 1'b0;
    endtask

    // monitor pops expected issues; also answers starts with done 3 cycles later when enabled
    initial forever begin
        int had;
        @(negedge clk);
        had = exp_q.size();
        if (auto_en && auto_done && had != 0) chk("b2b_start_after_done", vpu_start, 1);
        if (vpu_start) begin
            if (had == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL issue_without_entry: got start=1, want no start");
            end else chk("issue_order", vpu_instr, exp_q.pop_front());
        end
        auto_done = auto_en && dcnt == 1;
        if (vpu_start) dcnt = 3;
        else if (dcnt > 0) dcnt--;
    end

    initial begin
        logic acc;
        vpu_instr_t f;
        int k;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_q_count", q_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", vpu_start, 0);
        chk("rst_retired", retired, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_instr", vpu_instr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        push(mk(VPU_VLOAD, 13'h040, 10'h011), acc);
        chk("t1_acc", acc, 1);
        chk("t1_no_start_after_e0", vpu_start, 0);
        @(negedge clk);
        chk("t1_start_after_e1", vpu_start, 1);
        chk("t1_addr_a", vpu_instr.addr_a, 13'h040);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t1_single_pulse", vpu_start, 0);
            chk("t1_addr_held", vpu_instr.addr_a, 13'h040);
        end
        pulse_done();
        exp_ret++;
        chk("t1_retired", retired, exp_ret);
        chk("t1_busy_falls", busy, 0);
        chk("t1_addr_after_done", vpu_instr.addr_a, 13'h040);

        pulse_done();
        @(negedge clk);
        chk("spur_retired", retired, exp_ret);
        chk("spur_busy", busy, 0);
        chk("spur_start", vpu_start, 0);

        auto_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(mk(VPU_VCOMPUTE, 13'h100 + 13'(i * 7), 10'(10'h2A0 + i)), acc);
            chk("t2_acc", acc, 1);
        end
        k = 0;
        while (retired != 16'(exp_ret + 4) && k < 80) begin
            @(negedge clk);
            k++;
        end
        exp_ret += 4;
        chk("t2_retired", retired, exp_ret);
        chk("t2_busy", busy, 0);
        chk("t2_drained", exp_q.size(), 0);
        auto_en = 1'b0;

        for (int i = 0; i < 5; i++) begin
            push(mk(VPU_VSTORE, 13'h1F00 + 13'(i), 10'(10'h155 + i * 3)), acc);
            chk("t3_acc", acc, 1);
        end
        chk("t3_q_full", q_count, 4);
        chk("t3_not_ready", in_ready, 0);
        f = mk(VPU_SCALAR, 13'h0ABC, 10'h3FF);
        in_valid = 1'b1;
        in_instr = f;
        man_done = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        man_done = 1'b0;
        exp_ret++;
        chk("t3_refused_with_pop", q_count, 3);
        chk("t3_ready_again", in_ready, 1);
        push(f, acc);
        chk("t3_accept_after_done", acc, 1);
        chk("t3_q_full_again", q_count, 4);
        man_done = 1'b1;
        repeat (5) @(negedge clk);
        man_done = 1'b0;
        exp_ret += 5;
        chk("t3_retired", retired, exp_ret);
        chk("t3_busy", busy, 0);
        chk("t3_drained", exp_q.size(), 0);

`ifdef VPU_ISSUE_TIMEOUT_EN
        push(mk(VPU_VLOAD, 13'h0777, 10'h001), acc);
        push(mk(VPU_VCOMPUTE, 13'h0888, 10'h002), acc);
        wait_start(4);
        repeat (15) @(negedge clk);
        chk("to_no_err_early", err_timeout, 0);
        @(negedge clk);
        chk("to_err_set", err_timeout, 1);
        chk("to_not_retired", retired, exp_ret);
        @(negedge clk);
        chk("to_next_start", vpu_start, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_err_cleared", err_timeout, 0);
        repeat (14) @(negedge clk);
        chk("to_no_err_before_done", err_timeout, 0);
        pulse_done();
        exp_ret++;
        chk("to_done_on_expiry_no_err", err_timeout, 0);
        chk("to_done_on_expiry_retired", retired, exp_ret);
        chk("to_busy", busy, 0);
`else
        push(mk(VPU_VLOAD, 13'h0777, 10'h001), acc);
        wait_start(4);
        repeat (40) @(negedge clk);
        chk("nto_no_err", err_timeout, 0);
        chk("nto_still_busy", busy, 1);
        chk("nto_instr_held", vpu_instr.addr_a, 13'h0777);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        pulse_done();
        exp_ret++;
        chk("nto_retired", retired, exp_ret);
`endif

        for (int i = 0; i < 3; i++) push(mk(VPU_VSTORE, 13'h0300 + 13'(i), 10'h0F0), acc);
        chk("rst_mid_q_count", q_count, 2);
        chk("rst_mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_q_zero", q_count, 0);
        chk("rst_mid_start", vpu_start, 0);
        chk("rst_mid_retired", retired, 0);
        chk("rst_mid_ready", in_ready, 1);
        chk("rst_mid_instr", vpu_instr, 0);
        exp_q.delete();
        exp_ret = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle", busy, 0);
        push(mk(VPU_VLOAD, 13'h0155, 10'h0AA), acc);
        wait_start(4);
        pulse_done();
        exp_ret++;
        chk("rst_mid_recover", retired, exp_ret);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vpu_issue_ctrl.md
# vpu_issue_ctrl

Instruction issue sequencer in front of `vpu_simd`. It buffers decoded VPU instructions in a small FIFO and drives one instruction at a time onto the `vpu_simd` field and `start` inputs. It holds the fields stable until `vpu_simd` pulses `done`, which is required because `vpu_simd` muxes its BRAM and `done` outputs on `vpu_type`. It sits between the tensorcore instruction decoder and `vpu_simd`, and reports queue occupancy, retirements and stalls.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 1024: cycles `WAIT_DONE` may last before abort (timeout build only).
- `CNT_W`, 16: width of the retire counter.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  decoder offers an instruction.
- `in_instr`  in  `vpu_instr_t`  packed instruction fields.
- `in_ready`  out  1  = !full.
- `vpu_instr`  out  `vpu_instr_t`  registered fields to `vpu_simd`.
- `vpu_start`  out  1  one-cycle start pulse.
- `vpu_done`  in  1  `vpu_simd` done pulse.
- `q_count`  out  `$clog2(DEPTH+1)`  FIFO occupancy.
- `busy`  out  1  = (state != IDLE) | (q_count != 0).
- `retired`  out  `CNT_W`  count of completed instructions; wraps.
- `err_timeout`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `err_timeout`.

## Operation
- **Push:** on `in_valid & in_ready`, `in_instr` is written at the write pointer.
  - `in_ready` depends on the registered count only.
  - When the FIFO is full, a push is refused even if a pop happens in the same cycle.
- **States:** `IDLE` and `WAIT_DONE`.
- **IDLE:**
  - If FIFO is non-empty: pop the head into `vpu_instr`, set `vpu_start` = 1 for the next cycle, and go to `WAIT_DONE`.
  - `vpu_done` is ignored in `IDLE`.
- **WAIT_DONE:**
  - `vpu_instr` holds its value and `vpu_start` = 0.
  - On `vpu_done`, `retired` increments and:
    - if the FIFO is non-empty, pop and reissue on the same edge (zero-bubble back-to-back issue);
    - otherwise go to `IDLE`.
- **Simultaneous push and pop:** `q_count` stays unchanged. A push into an empty FIFO is not bypassed; it must be written before it can be popped.
- **Pointers:** wrap modulo `DEPTH`. `q_count` saturates at neither end: overflow and underflow are impossible by construction.
- **Clear and set in one cycle:** `err_clr` and a timeout in the same cycle → set wins.

## Timing
- **Reset values:** all outputs 0, except `in_ready` = 1. State = `IDLE`, pointers and counters 0, `vpu_instr` = 0.
- **Issue latency:** push accepted at edge E0 → `vpu_start` high in the cycle after E1, for exactly one cycle. `vpu_instr` is valid from that same cycle until the edge after `vpu_done`.
- **Back-to-back issue:** `vpu_done` at edge Ek with a queued entry → next `vpu_start` high in the cycle after Ek.
- **Reset mid-operation:** the FIFO is discarded and state returns to `IDLE`. Instructions in flight are lost; `vpu_simd` is reset by the same `rst_n`.

## Configuration
- Macro: `VPU_ISSUE_TIMEOUT_EN`.
- **Defined:**
  - A cycle counter clears on every `vpu_start`.
  - If `WAIT_DONE` reaches `TIMEOUT_CYCLES` cycles without `vpu_done`: set `err_timeout`, abandon the instruction (`retired` not incremented), and go to `IDLE`. Issue continues from the queue.
  - A `vpu_done` arriving on the expiry cycle takes priority: normal retire, no error.
- **Undefined:**
  - No counter is built; `err_timeout` is tied 0 and `err_clr` is unused.
  - `WAIT_DONE` waits indefinitely.

## Structure
- Package `vpu_pkg` holds:
  - `vpu_instr_t`, a packed struct of `addr_a`, `addr_b`, `addr_out` and `addr_const` (13 bits each), `opcode` (10), `vpu_type` (3), `vreg_dst`, `vreg_a`, `vreg_b`, `vpu_opcode` (3 each) and `scalar_b` (1); 78 bits total.
  - `vpu_type` constants `VPU_SCALAR`=0, `VPU_VLOAD`=1, `VPU_VSTORE`=2, `VPU_VCOMPUTE`=3.
- Sub-module `vpu_instr_fifo`: synchronous FIFO, registered `count`, no bypass.
- The sequencer FSM and timeout counter live in `vpu_issue_ctrl`.

## Test plan
- **Single issue:** reset, push one VLOAD (`vpu_type`=1, `addr_a`=0x040), `vpu_done` 10 cycles after start → exactly one `vpu_start` pulse 2 cycles after push; `vpu_instr.addr_a` = 0x040 held throughout; `retired`=1; `busy` falls.
- **Back-to-back:** push 4 instructions while the first waits; answer each start with `vpu_done` 3 cycles later → starts follow each done by 1 cycle; `retired`=4; issue order matches push order.
- **Full:** push with `vpu_done` withheld → FIFO holds 4 entries after one has issued; `in_ready`=0 with `q_count`=4; a 6th push is refused; after one `vpu_done` the push is accepted.
- **Spurious done:** pulse `vpu_done` in `IDLE` → no state change, `retired` unchanged.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=16):** issue and never send done → `err_timeout`=1 after 16 cycles; next queued instruction starts; `err_clr` clears the flag. Same run with done on cycle 16 → no error, `retired`=1.
- **Reset mid-operation:** assert `rst_n`=0 during `WAIT_DONE` with 2 queued → `q_count`=0, `vpu_start`=0, `retired`=0, `in_ready`=1 immediately.
